data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter ADDR_WORDS, default 1024, meaning storage depth in 32-bit words; power of two.
REQ-002 Parameter READ_LATENCY, default 2, meaning cycles from read acceptance to data valid; legal range 1..7.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 data_address_2DM  input  32  byte address; word index = bits [log2(ADDR_WORDS)+1:2], upper bits ignored (wrap).
REQ-007 data_write_2DM  input  32  store data; byte 0 = bits [31:24] (big-endian lanes).
REQ-008 data_write_size_2DM  input  2  0=word, 1=byte, 2=halfword, 3=reserved.
REQ-009 MemRead_2DM  input  1  read request level.
REQ-010 MemWrite_2DM  input  1  write request level.
REQ-011 data_read_fDM  output  32  full aligned word read; initiator does lane extraction.
REQ-012 DM_Done  output  1  one-cycle pulse: read data valid or write committed.
REQ-013 DM_Stall  output  1  = (MemRead_2DM | MemWrite_2DM) & ~DM_Done; combinational.
REQ-014 DM_Error  output  1  one-cycle pulse with DM_Done for a rejected store.

Function
REQ-015 FSM states SHALL be IDLE, READ_WAIT, WRITE, RMW_READ, RMW_WRITE, DONE.
REQ-016 Request SHALL be accepted only in IDLE; initiator holds address/data/size/strobes stable until DM_Done.
REQ-017 MemRead_2DM and MemWrite_2DM both high SHALL be treated as a write.
REQ-018 Read accepted in cycle 0 SHALL give DM_Done=1 and valid data_read_fDM in cycle READ_LATENCY (IDLE->READ_WAIT, down-counter, ->DONE).
REQ-019 data_read_fDM SHALL hold its last read value until the next read completes; writes SHALL not change it.
REQ-020 Word store (size 0) accepted in cycle 0: array written at end of cycle 0, DM_Done in cycle 1 (IDLE->WRITE->IDLE).
REQ-021 Byte/halfword store: RMW_READ in cycle 0, merge and write at end of cycle 1, DM_Done in cycle 2.
REQ-022 Byte merge SHALL replace lane address[1:0] with data_write_2DM[7:0]; other lanes unchanged.
REQ-023 Halfword merge SHALL replace bits [31:16] for address[1:0]=00 and [15:0] for 10 with data_write_2DM[15:0].
REQ-024 Halfword at address[1:0]=01/11 or size 3 SHALL not write, and SHALL pulse DM_Error with DM_Done in cycle 1.
REQ-025 Word store SHALL ignore address[1:0]; reads SHALL always return the word at address[31:2].
REQ-026 Cycle after DM_Done the FSM SHALL be IDLE; a still-asserted request there is a new request.
REQ-027 Read following a write to the same word SHALL return the written value (no stale data).

Reset
REQ-028 RESET high at a clock edge SHALL force IDLE, zero the latency counter, data_read_fDM=0, DM_Done=0, DM_Error=0.
REQ-029 Reset mid-operation SHALL abandon it; a pending RMW write SHALL not reach the array.
REQ-030 Array contents SHALL not be cleared by reset.

Structure
REQ-031 Shared package dm_pkg SHALL hold size encodings (DM_SIZE_WORD/BYTE/HALF) and the FSM state enum.
REQ-032 Storage SHALL be sub-module dm_storage_array: single-port, synchronous write, registered read, ADDR_WORDS x 32.
REQ-033 Lane merge SHALL be a combinational function in dm_pkg, shared with bench reference model.

Verification
REQ-034 Write word 0xDEADBEEF to 0x40, then read 0x40 -> DM_Done cycle 1; read data 0xDEADBEEF in cycle READ_LATENCY, DM_Stall high until then.
REQ-035 Word 0x11223344 at 0x80; SB 0xAA to 0x82 -> DM_Done cycle 2; read 0x80 -> 0x1122AA44.
REQ-036 SH 0xBEEF to 0x80 then 0x82 on 0x00000000 -> 0xBEEF0000 then 0xBEEFBEEF; SH to 0x81 -> DM_Error, word unchanged.
REQ-037 Both strobes high, word 0x5 to 0x10 -> treated as write; later read 0x10 -> 0x00000005; address 0x10+4*ADDR_WORDS aliases 0x10.
REQ-038 RESET asserted in RMW_WRITE cycle of SB 0xFF to 0x20 -> no write; read 0x20 returns prior value; data_read_fDM=0 right after reset.
REQ-039 Back-to-back reads held across DM_Done -> second read completes READ_LATENCY+1 cycles after first DM_Done.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder and anything that models it.
//   - dm_size_e   : store-size encodings carried on data_write_size_2DM
//   - dm_state_e  : responder FSM states
//   - dm_store_legal() : decides whether a store is executable or rejected
//   - dm_lane_merge()  : big-endian byte/halfword merge into a 32-bit word
package dm_pkg;

  typedef enum logic [1:0] {
    DM_SIZE_WORD = 2'd0,
    DM_SIZE_BYTE = 2'd1,
    DM_SIZE_HALF = 2'd2,
    DM_SIZE_RSVD = 2'd3
  } dm_size_e;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE,
    RMW_READ,
    RMW_WRITE,
    DONE
  } dm_state_e;

  // Misaligned halfwords and the reserved size are rejected without touching memory.
  function automatic logic dm_store_legal(input logic [1:0] size, input logic [1:0] off);
    case (size)
      DM_SIZE_WORD: return 1'b1;
      DM_SIZE_BYTE: return 1'b1;
      DM_SIZE_HALF: return (off[0] == 1'b0);
      default:      return 1'b0;
    endcase
  endfunction

  // Lane 0 is bits [31:24]; the store payload always sits in the low bits of wdata.
  function automatic logic [31:0] dm_lane_merge(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
    logic [31:0] merged;
    merged = old_word;
    case (size)
      DM_SIZE_WORD: merged = wdata;
      DM_SIZE_BYTE: begin
        case (off)
          2'd0: merged[31:24] = wdata[7:0];
          2'd1: merged[23:16] = wdata[7:0];
          2'd2: merged[15:8]  = wdata[7:0];
          default: merged[7:0] = wdata[7:0];
        endcase
      end
      DM_SIZE_HALF: begin
        if (off == 2'd0)      merged[31:16] = wdata[15:0];
        else if (off == 2'd2) merged[15:0]  = wdata[15:0];
      end
      default: merged = old_word;
    endcase
    return merged;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Initiator <-> data memory bus.
//   master : drives address, store data/size and the read/write request levels
//   slave  : returns the aligned read word plus Done/Stall/Error status
interface data_mem_responder_if;
  logic [31:0] data_address_2DM;
  logic [31:0] data_write_2DM;
  logic [1:0]  data_write_size_2DM;
  logic        MemRead_2DM;
  logic        MemWrite_2DM;
  logic [31:0] data_read_fDM;
  logic        DM_Done;
  logic        DM_Stall;
  logic        DM_Error;

  modport master (
    output data_address_2DM, data_write_2DM, data_write_size_2DM, MemRead_2DM, MemWrite_2DM,
    input  data_read_fDM, DM_Done, DM_Stall, DM_Error
  );

  modport slave (
    input  data_address_2DM, data_write_2DM, data_write_size_2DM, MemRead_2DM, MemWrite_2DM,
    output data_read_fDM, DM_Done, DM_Stall, DM_Error
  );
endinterface

// File: rtl/data_mem_responder_storage_array.sv
// ADDR_WORDS x 32 single-port storage: synchronous write, registered read.
//   CLK     : rising-edge clock
//   wr_en   : write wr_data to addr at this edge
//   addr    : word index
//   wr_data : word to store
//   rd_data : word at addr as of the previous edge (read-before-write)
module dm_storage_array #(
  parameter int ADDR_WORDS = 1024,
  parameter int AW         = $clog2(ADDR_WORDS)
) (
  input  logic          CLK,
  input  logic          wr_en,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [ADDR_WORDS];

  // NOTE: the array has no reset; contents must survive RESET, and a reset
  // term would stop this mapping onto a RAM macro.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[addr] <= wr_data;
    rd_data <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: serves word reads with a fixed latency, word stores in
// one cycle and byte/halfword stores by read-modify-write.
//   CLK   : rising-edge clock
//   RESET : synchronous, active-high; abandons any operation in flight
//   bus   : slave side of the initiator bus (request in, data/status out)
module data_mem_responder
  import dm_pkg::*;
#(
  parameter int ADDR_WORDS   = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  data_mem_responder_if.slave  bus
);

  localparam int AW = $clog2(ADDR_WORDS);

  dm_state_e   state_q, state_d;
  logic [2:0]  lat_cnt_q, lat_cnt_d;
  logic        is_read_q, is_read_d;
  logic        err_q, err_d;
  logic [31:0] rd_hold_q;
  logic [AW-1:0] word_idx;
  logic [31:0] array_rdata, array_wdata;
  logic        array_we, array_we_raw;
  logic        wr_req, rd_req, done;
  logic [1:0]  lane;

  // Writes win when both strobes are high.
  assign wr_req   = bus.MemWrite_2DM;
  assign rd_req   = bus.MemRead_2DM & ~bus.MemWrite_2DM;
  assign lane     = bus.data_address_2DM[1:0];
  // Upper address bits fall off the truncation, so addresses wrap modulo the depth.
  assign word_idx = AW'(bus.data_address_2DM >> 2);

  // The array reads the held address every cycle, so its output is current
  // for both the read completion and the RMW merge.
  dm_storage_array #(.ADDR_WORDS(ADDR_WORDS), .AW(AW)) u_array (
    .CLK     (CLK),
    .wr_en   (array_we),
    .addr    (word_idx),
    .wr_data (array_wdata),
    .rd_data (array_rdata)
  );

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    is_read_d    = is_read_q;
    err_d        = err_q;
    array_we_raw = 1'b0;
    array_wdata  = bus.data_write_2DM;

    case (state_q)
      IDLE: begin
        is_read_d = 1'b0;
        err_d     = 1'b0;
        if (wr_req) begin
          if (bus.data_write_size_2DM == DM_SIZE_WORD) begin
            array_we_raw = 1'b1;
            state_d      = WRITE;
          end else if (dm_store_legal(bus.data_write_size_2DM, lane)) begin
            // The read half of the RMW is the array read launched this cycle,
            // so the FSM steps straight to the merge/write cycle.
            state_d = RMW_WRITE;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end else if (rd_req) begin
          is_read_d = 1'b1;
          if (READ_LATENCY <= 1) begin
            state_d = DONE;
          end else begin
            lat_cnt_d = 3'(READ_LATENCY - 2);
            state_d   = READ_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (lat_cnt_q == 3'd0) state_d = DONE;
        else                   lat_cnt_d = lat_cnt_q - 3'd1;
      end
      RMW_WRITE: begin
        array_we_raw = 1'b1;
        array_wdata  = dm_lane_merge(array_rdata, bus.data_write_2DM,
                                     bus.data_write_size_2DM, lane);
        state_d      = DONE;
      end
      WRITE, DONE: state_d = IDLE;
      default:     state_d = IDLE;
    endcase

    // A reset edge must not let a pending store land in the array.
    array_we = array_we_raw & ~RESET;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      lat_cnt_q <= 3'd0;
      is_read_q <= 1'b0;
      err_q     <= 1'b0;
      rd_hold_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      is_read_q <= is_read_d;
      err_q     <= err_d;
      if (state_q == DONE && is_read_q) rd_hold_q <= array_rdata;
    end
  end

  // Word stores report in WRITE; everything else reports in DONE.
  assign done              = (state_q == DONE) || (state_q == WRITE);
  assign bus.DM_Done       = done;
  assign bus.DM_Error      = (state_q == DONE) && err_q;
  assign bus.DM_Stall      = (bus.MemRead_2DM | bus.MemWrite_2DM) & ~done;
  // Fresh array data during the completing read; the held value otherwise.
  assign bus.data_read_fDM = (state_q == DONE && is_read_q) ? array_rdata : rd_hold_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a table of directed bus
// operations with hand-computed results, plus hand-written sequences for
// reset state, reset during an RMW write, and back-to-back held reads.
module tb_data_mem_responder;
  import dm_pkg::*;

  localparam int ADDR_WORDS   = 1024;
  localparam int READ_LATENCY = 2;
  localparam int RL           = READ_LATENCY;

  logic CLK = 1'b0;
  logic RESET;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .ADDR_WORDS   (ADDR_WORDS),
    .READ_LATENCY (READ_LATENCY)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_BOTH} op_e;

  typedef struct packed {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [3:0]  exp_cyc;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        vecs[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_rd_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input op_e op, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] s, input int cyc, input logic err,
                              input logic [31:0] rd);
    vec_t v;
    v.op      = op;
    v.addr    = a;
    v.wdata   = d;
    v.size    = s;
    v.exp_cyc = 4'(cyc);
    v.exp_err = err;
    v.exp_rd  = rd;
    return v;
  endfunction

  task automatic drive_idle();
    bus.MemRead_2DM  = 1'b0;
    bus.MemWrite_2DM = 1'b0;
  endtask

  // Presents one request in cycle 0, watches for DM_Done, then drops the request.
  task automatic run_op(input vec_t v, input int idx);
    int          done_cyc;
    logic        seq_ok, got_err;
    logic [31:0] got_rd, post_rd;
    @(posedge CLK); #1;
    bus.data_address_2DM    = v.addr;
    bus.data_write_2DM      = v.wdata;
    bus.data_write_size_2DM = v.size;
    bus.MemRead_2DM         = (v.op != OP_WRITE);
    bus.MemWrite_2DM        = (v.op != OP_READ);
    done_cyc = -1;
    seq_ok   = 1'b1;
    got_err  = 1'b0;
    got_rd   = '0;
    for (int c = 0; c < 16 && done_cyc < 0; c++) begin
      @(negedge CLK);
      if (bus.DM_Done === 1'b1) begin
        done_cyc = c;
        got_rd   = bus.data_read_fDM;
        got_err  = bus.DM_Error;
        if (bus.DM_Stall !== 1'b0) seq_ok = 1'b0;
      end else if (bus.DM_Stall !== 1'b1 || bus.DM_Error !== 1'b0) begin
        seq_ok = 1'b0;
      end
    end
    @(posedge CLK); #1;
    drive_idle();
    @(negedge CLK);
    if (bus.DM_Done !== 1'b0 || bus.DM_Error !== 1'b0 || bus.DM_Stall !== 1'b0) seq_ok = 1'b0;
    post_rd = bus.data_read_fDM;

    check($sformatf("vec%0d done_cycle", idx), done_cyc, 32'(v.exp_cyc));
    check($sformatf("vec%0d error", idx), 32'(got_err), 32'(v.exp_err));
    check($sformatf("vec%0d stall_pulse", idx), 32'(seq_ok), 32'd1);
    if (v.op == OP_READ) begin
      check($sformatf("vec%0d read_data", idx), got_rd, v.exp_rd);
      last_rd_exp = v.exp_rd;
    end
    check($sformatf("vec%0d read_hold", idx), post_rd, last_rd_exp);
  endtask

  initial begin
    int          d1, d2;
    logic [31:0] r1, r2;

    // Stimulus table: each write's expected read-back is worked out by hand.
    vecs.push_back(mk(OP_WRITE, 32'h40,   32'hDEADBEEF, DM_SIZE_WORD, 1,  1'b0, 32'h0));
    vecs.push_back(mk(OP_READ,  32'h40,   32'h0,        DM_SIZE_WORD, RL, 1'b0, 32'hDEADBEEF));
    vecs.push_back(mk(OP_WRITE, 32'h80,   32'h11223344, DM_SIZE_WORD, 1,  1'b0, 32'h0));
    vecs.push_back(mk(OP_WRITE, 32'h82,   32'h000000AA, DM_SIZE_BYTE, 2,  1'b0, 32'h0));
    vecs.push_back(mk(OP_READ,  32'h80,   32'h0,        DM_SIZE_WORD, RL, 1'b0, 32'h1122AA44));
    vecs.push_back(mk(OP_WRITE, 32'h80,   32'h00000000, DM_SIZE_WORD, 1,  1'b0, 32'h0));
    vecs.push_back(mk(OP_WRITE, 32'h80,   32'h0000BEEF, DM_SIZE_HALF, 2,  1'b0, 32'h0));
    vecs.push_back(mk(OP_READ,  32'h80,   32'h0,        DM_SIZE_WORD, RL, 1'b0, 32'hBEEF0000));
    vecs.push_back(mk(OP_WRITE, 32'h82,   32'h0000BEEF, DM_SIZE_HALF, 2,  1'b0, 32'h0));
    vecs.push_back(mk(OP_READ,  32'h80,   32'h0,        DM_SIZE_WORD, RL, 1'b0, 32'hBEEFBEEF));
    vecs.push_back(mk(OP_WRITE, 32'h81,   32'h00001234, DM_SIZE_HALF, 1,  1'b1, 32'h0));
    vecs.push_back(mk(OP_WRITE, 32'h83,   32'h00005678, DM_SIZE_HALF, 1,  1'b1, 32'h0));
    vecs.push_back(mk(OP_WRITE, 32'h80,   32'hFFFFFFFF, DM_SIZE_RSVD, 1,  1'b1, 32'h0));
    vecs.push_back(mk(OP_READ,  32'h80,   32'h0,        DM_SIZE_WORD, RL, 1'b0, 32'hBEEFBEEF));
    vecs.push_back(mk(OP_BOTH,  32'h10,   32'h00000005, DM_SIZE_WORD, 1,  1'b0, 32'h0));
    vecs.push_back(mk(OP_READ,  32'h10,   32'h0,        DM_SIZE_WORD, RL, 1'b0, 32'h00000005));
    vecs.push_back(mk(OP_READ,  32'h10 + 4*ADDR_WORDS, 32'h0, DM_SIZE_WORD, RL, 1'b0, 32'h00000005));
    vecs.push_back(mk(OP_WRITE, 32'h14 + 4*ADDR_WORDS, 32'h00000077, DM_SIZE_WORD, 1, 1'b0, 32'h0));
    vecs.push_back(mk(OP_READ,  32'h14,   32'h0,        DM_SIZE_WORD, RL, 1'b0, 32'h00000077));
    vecs.push_back(mk(OP_WRITE, 32'h20,   32'h01020304, DM_SIZE_WORD, 1,  1'b0, 32'h0));
    vecs.push_back(mk(OP_WRITE, 32'h23,   32'h123456FF, DM_SIZE_BYTE, 2,  1'b0, 32'h0));
    vecs.push_back(mk(OP_WRITE, 32'h20,   32'h00000099, DM_SIZE_BYTE, 2,  1'b0, 32'h0));
    vecs.push_back(mk(OP_WRITE, 32'h21,   32'h00000055, DM_SIZE_BYTE, 2,  1'b0, 32'h0));
    vecs.push_back(mk(OP_READ,  32'h22,   32'h0,        DM_SIZE_WORD, RL, 1'b0, 32'h995503FF));
    vecs.push_back(mk(OP_WRITE, 32'h27,   32'hCAFEF00D, DM_SIZE_WORD, 1,  1'b0, 32'h0));
    vecs.push_back(mk(OP_READ,  32'h24,   32'h0,        DM_SIZE_WORD, RL, 1'b0, 32'hCAFEF00D));
    vecs.push_back(mk(OP_READ,  32'h20,   32'h0,        DM_SIZE_WORD, RL, 1'b0, 32'h995503FF));

    // Reset state.
    RESET                   = 1'b1;
    bus.data_address_2DM    = '0;
    bus.data_write_2DM      = '0;
    bus.data_write_size_2DM = '0;
    drive_idle();
    last_rd_exp = 32'h0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("reset DM_Done", 32'(bus.DM_Done), 32'd0);
    check("reset DM_Error", 32'(bus.DM_Error), 32'd0);
    check("reset DM_Stall", 32'(bus.DM_Stall), 32'd0);
    check("reset data_read_fDM", bus.data_read_fDM, 32'h0);

    foreach (vecs[i]) run_op(vecs[i], i);

    // Reset lands on the RMW_WRITE cycle of SB 0xFF to 0x20: the merge must be dropped.
    @(posedge CLK); #1;
    bus.data_address_2DM    = 32'h20;
    bus.data_write_2DM      = 32'h000000FF;
    bus.data_write_size_2DM = DM_SIZE_BYTE;
    bus.MemWrite_2DM        = 1'b1;
    @(posedge CLK); #1;
    check("rmw cycle1 DM_Done", 32'(bus.DM_Done), 32'd0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    drive_idle();
    @(negedge CLK);
    check("post-reset data_read_fDM", bus.data_read_fDM, 32'h0);
    check("post-reset DM_Done", 32'(bus.DM_Done), 32'd0);
    check("post-reset DM_Error", 32'(bus.DM_Error), 32'd0);
    last_rd_exp = 32'h0;
    run_op(mk(OP_READ, 32'h20, 32'h0, DM_SIZE_WORD, RL, 1'b0, 32'h995503FF), 100);

    // Back-to-back reads with MemRead held across the first DM_Done.
    @(posedge CLK); #1;
    bus.data_address_2DM = 32'h40;
    bus.MemRead_2DM      = 1'b1;
    d1 = -1;
    d2 = -1;
    r1 = '0;
    r2 = '0;
    for (int c = 0; c < 30 && d2 < 0; c++) begin
      @(negedge CLK);
      if (bus.DM_Done === 1'b1) begin
        if (d1 < 0) begin d1 = c; r1 = bus.data_read_fDM; end
        else        begin d2 = c; r2 = bus.data_read_fDM; end
      end
    end
    @(posedge CLK); #1;
    drive_idle();
    check("b2b first done_cycle", d1, RL);
    check("b2b second done gap", d2 - d1, RL + 1);
    check("b2b first data", r1, 32'hDEADBEEF);
    check("b2b second data", r2, 32'hDEADBEEF);

    repeat (2) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
